ring_scan_driver: RTL

//  Consumes the one-hot phase vector of the upstream 4-bit ring counter, checks it is a

---
 rtl/ring_scan_pkg.sv | 31 +++
 rtl/seg7_hex_decode.sv | 11 +
 rtl/ring_scan_driver.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ring_scan_pkg.sv
// Shared types, segment table and one-hot helpers for the ring scan display driver.
package ring_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned MAX_N = 32;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic onehot_legal(input logic [MAX_N-1:0] x);
        return (x != '0) && ((x & (x - MAX_N'(1))) == '0);
    endfunction

    // Rotate-left by one within the low n bits
    function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] p, input int unsigned n);
        logic [MAX_N-1:0] mask;
        mask = (n >= MAX_N) ? '1 : ((MAX_N'(1) << n) - MAX_N'(1));
        return ((p << 1) | (p >> (n - 1))) & mask;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-digit to 7-segment decoder; every code maps to a glyph.
module seg7_hex_decode
    import ring_scan_pkg::*;
(
    input  logic [3:0]       hex,
    output logic [SEG_W-1:0] seg_c
);

    assign seg_c = SEG_HEX[hex];

endmodule

// File: rtl/ring_scan_driver.sv
// Scans N hex digits onto a 7-seg display, following a one-hot ring phase with
// dead-time blanking, sticky fault detection and a completed-rotation counter.
module ring_scan_driver
    import ring_scan_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned DEAD_CYC = 1,
    parameter int unsigned REV_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         count,
    input  logic [4*N-1:0]       digits,
    input  logic                 clr_fault,
    output logic [N-1:0]         anode,
    output logic [SEG_W-1:0]     seg,
    output logic [$clog2(N)-1:0] phase_idx,
    output logic                 fault,
    output logic [REV_W-1:0]     rev_count
);

    localparam int unsigned IW      = $clog2(N);
    localparam int unsigned DW      = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [DW-1:0] DEAD_LD = (DEAD_CYC == 0) ? '0 : DW'(DEAD_CYC - 1);

    state_t           state;
    logic [N-1:0]     count_q;
    logic [N-1:0]     cur;
    logic [DW-1:0]    dead;

    logic             count_legal_c;
    logic [N-1:0]     next_c;
    logic [N-1:0]     sel_c;
    logic [IW-1:0]    sel_idx_c;
    logic [3:0]       sel_digit_c;
    logic [SEG_W-1:0] sel_seg_c;
    logic             enter_c;
    logic             to_fault_c;
    logic             show_c;
    logic             wrap_c;

    assign count_legal_c = onehot_legal(MAX_N'(count_q));
    assign next_c        = N'(rotl1(MAX_N'(cur), N));

    // Without blanking the phase being entered is driven on the same edge
    assign sel_c = ((DEAD_CYC == 0) && (state != BLANK)) ? count_q : cur;

    // Index and digit of the selected phase
    always_comb begin
        sel_idx_c   = '0;
        sel_digit_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel_c[i]) begin
                sel_idx_c   = sel_idx_c | IW'(i);
                sel_digit_c = sel_digit_c | digits[4*i +: 4];
            end
        end
    end

    seg7_hex_decode u_dec (
        .hex   (sel_digit_c),
        .seg_c (sel_seg_c)
    );

    // Phase checking: decide whether to start a new phase, fault, or keep driving
    always_comb begin
        enter_c    = 1'b0;
        to_fault_c = 1'b0;
        show_c     = 1'b0;
        wrap_c     = 1'b0;
        case (state)
            IDLE: begin
                enter_c    = count_legal_c;
                to_fault_c = !count_legal_c && (count_q != '0);
            end
            BLANK, DRIVE: begin
                if (count_q == cur) begin
                    show_c = (state == DRIVE) || (dead == '0);
                end else if (count_q == next_c) begin
                    enter_c = 1'b1;
                    wrap_c  = cur[N-1];
                end else begin
                    to_fault_c = 1'b1;
                end
            end
            FAULT: begin
                enter_c = clr_fault && count_legal_c;
            end
            default: begin
                to_fault_c = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count_q   <= '0;
            cur       <= '0;
            dead      <= '0;
            anode     <= '0;
            seg       <= '0;
            phase_idx <= '0;
            fault     <= 1'b0;
            rev_count <= '0;
        end else begin
            count_q <= count;
            if (to_fault_c) begin
                state <= FAULT;
                fault <= 1'b1;
                anode <= '0;
                seg   <= '0;
            end else if (enter_c) begin
                cur   <= count_q;
                fault <= 1'b0;
                if (wrap_c) begin
                    rev_count <= rev_count + REV_W'(1);
                end
                if (DEAD_CYC == 0) begin
                    state     <= DRIVE;
                    anode     <= count_q;
                    seg       <= sel_seg_c;
                    phase_idx <= sel_idx_c;
                end else begin
                    state <= BLANK;
                    dead  <= DEAD_LD;
                    anode <= '0;
                    seg   <= '0;
                end
            end else if (show_c) begin
                state     <= DRIVE;
                anode     <= cur;
                seg       <= sel_seg_c;
                phase_idx <= sel_idx_c;
            end else if (state == BLANK) begin
                dead <= dead - DW'(1);
            end
        end
    end

endmodule
